// File: rtl/scr1_memif_pkg.sv
// Shared SCR1 memory-interface definitions.
// Holds the memory response code enum used on every SCR1 memory port, plus
// the port count and owner-id type used by the instruction-memory arbiter.
package scr1_memif_pkg;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // Number of requesters sharing the imem port.
    localparam int SCR1_IMEM_ARB_PORTS = 2;

    // Identifies which requester issued a transaction (0 = core fetch, 1 = secondary).
    typedef logic type_scr1_imem_arb_owner_t;

endpackage

// File: rtl/scr1_imem_arb_tagq.sv
// In-order owner-tag queue for the imem arbiter.
// One-bit-wide synchronous FIFO: each accepted request pushes its owner id,
// each memory response pops the head to route the data back.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears count/pointers)
//   push, din    enqueue owner id (ignored when full)
//   pop          dequeue head (ignored when empty)
//   head         owner id of the oldest outstanding transaction
//   full, empty  derived from the registered occupancy count
module scr1_imem_arb_tagq
    import scr1_memif_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  type_scr1_imem_arb_owner_t din,
    input  logic                      pop,
    output type_scr1_imem_arb_owner_t head,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps DEPTH=1 correct, where the pointer is wider than needed.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scr1_imem_arb.sv
// Two-port arbiter for the SCR1 instruction-memory port.
// Port 0 is the core fetch unit, port 1 a secondary fetcher (debug/trace).
// A grant is held (locked) until the memory accepts it; owners of accepted
// requests are queued in order so each response returns to its issuer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sN_req/sN_addr           requester fetch request and address
//   sN_req_ack               request accepted this cycle
//   sN_rdata/sN_resp         routed read data and response code
//   imem_req/imem_addr       arbitrated request to the memory port
//   imem_req_ack             memory accepted the request
//   imem_rdata/imem_resp     memory read data and response code
//   err_unexp_resp           sticky: response seen with nothing outstanding
module scr1_imem_arb
    import scr1_memif_pkg::*;
#(
    parameter int OUTST_DEPTH = 2,
    parameter bit ARB_RR      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_req,
    input  logic [31:0] s0_addr,
    output logic        s0_req_ack,
    output logic [31:0] s0_rdata,
    output logic [1:0]  s0_resp,
    input  logic        s1_req,
    input  logic [31:0] s1_addr,
    output logic        s1_req_ack,
    output logic [31:0] s1_rdata,
    output logic [1:0]  s1_resp,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_req_ack,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_resp,
    output logic        err_unexp_resp
);

    localparam logic ST_UNLOCKED = 1'b0;
    localparam logic ST_LOCKED   = 1'b1;

    logic                               lock_state;
    type_scr1_imem_arb_owner_t          lock_owner;
    type_scr1_imem_arb_owner_t          rr_ptr;
    logic [SCR1_IMEM_ARB_PORTS-1:0]     req_vec;
    logic                               gnt_vld;
    type_scr1_imem_arb_owner_t          gnt;
    logic                               gnt_req;
    logic                               accept;
    logic                               resp_vld;
    logic                               pop;
    type_scr1_imem_arb_owner_t          q_head;
    logic                               q_full;
    logic                               q_empty;

    assign req_vec = {s1_req, s0_req};

    always_comb begin
        gnt_vld = 1'b1;
        gnt     = 1'b0;
        if (lock_state == ST_LOCKED) begin
            gnt = lock_owner;
        end else begin
            case (req_vec)
                2'b11:   gnt = ARB_RR ? rr_ptr : 1'b0;
                2'b10:   gnt = 1'b1;
                2'b01:   gnt = 1'b0;
                default: gnt_vld = 1'b0;
            endcase
        end
    end

    // A locked owner that drops req still holds the grant for this cycle,
    // so imem_req falls and the lock is released at the edge.
    assign gnt_req   = gnt ? s1_req : s0_req;
    assign imem_req  = gnt_vld & gnt_req & ~q_full;
    assign imem_addr = ~gnt_vld ? 32'h0 : (gnt ? s1_addr : s0_addr);

    // Nothing is accepted or routed while reset is held.
    assign accept     = imem_req & imem_req_ack & ~rst;
    assign s0_req_ack = accept & (gnt == 1'b0);
    assign s1_req_ack = accept & (gnt == 1'b1);

    assign resp_vld = (imem_resp != SCR1_MEM_RESP_NOTRDY);
    assign pop      = resp_vld & ~q_empty & ~rst;
    assign s0_resp  = (pop & (q_head == 1'b0)) ? imem_resp : SCR1_MEM_RESP_NOTRDY;
    assign s1_resp  = (pop & (q_head == 1'b1)) ? imem_resp : SCR1_MEM_RESP_NOTRDY;
    assign s0_rdata = imem_rdata;
    assign s1_rdata = imem_rdata;

    scr1_imem_arb_tagq #(
        .DEPTH (OUTST_DEPTH)
    ) i_tagq (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (gnt),
        .pop   (pop),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state     <= ST_UNLOCKED;
            lock_owner     <= 1'b0;
            rr_ptr         <= 1'b0;
            err_unexp_resp <= 1'b0;
        end else begin
            // Lock is frozen while the tag queue is full.
            if (!q_full) begin
                if (lock_state == ST_LOCKED) begin
                    if (accept || !gnt_req) begin
                        lock_state <= ST_UNLOCKED;
                    end
                end else if (imem_req && !imem_req_ack) begin
                    lock_state <= ST_LOCKED;
                    lock_owner <= gnt;
                end
            end
            if (accept) begin
                rr_ptr <= ~gnt;
            end
            if (resp_vld && q_empty) begin
                err_unexp_resp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scr1_imem_arb.sv
module tb_scr1_imem_arb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_req, s1_req;
    logic [31:0] s0_addr, s1_addr;
    logic        s0_req_ack, s1_req_ack;
    logic [31:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_resp, s1_resp;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_req_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;
    logic        err_unexp_resp;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding owners as a queue, a held grant, a
    // round-robin preference and the sticky error.
    int mq[$];
    int lock_own = -1;
    int rr       = 0;
    bit m_err    = 0;
    bit last_ack[2];

    scr1_imem_arb #(.OUTST_DEPTH(DEPTH), .ARB_RR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_addr(s0_addr), .s0_req_ack(s0_req_ack),
        .s0_rdata(s0_rdata), .s0_resp(s0_resp),
        .s1_req(s1_req), .s1_addr(s1_addr), .s1_req_ack(s1_req_ack),
        .s1_rdata(s1_rdata), .s1_resp(s1_resp),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ack(imem_req_ack),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .err_unexp_resp(err_unexp_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are applied just after a negedge; outputs are checked a little
    // later against the model, then the model advances as the posedge would.
    task automatic cyc();
        int          win;
        bit          full, acc, popd;
        bit          r[2];
        logic [31:0] a[2];
        logic        e_req;
        logic [31:0] e_addr;
        logic [1:0]  er[2];
        #1;
        r[0] = s0_req; r[1] = s1_req;
        a[0] = s0_addr; a[1] = s1_addr;
        full = (mq.size() == DEPTH);
        if (lock_own >= 0)      win = lock_own;
        else if (r[0] && r[1])  win = rr;
        else if (r[0])          win = 0;
        else if (r[1])          win = 1;
        else                    win = -1;
        e_req  = (win >= 0) && r[win] && !full;
        e_addr = (win < 0) ? 32'h0 : a[win];
        acc    = e_req && imem_req_ack && !rst;
        popd   = (imem_resp != 2'b00) && (mq.size() > 0) && !rst;
        er[0]  = 2'b00; er[1] = 2'b00;
        if (popd) er[mq[0]] = imem_resp;

        if (!rst) begin
            chk("imem_req", 32'(imem_req), 32'(e_req));
            chk("imem_addr", imem_addr, e_addr);
            chk("err", 32'(err_unexp_resp), 32'(m_err));
        end
        chk("s0_ack", 32'(s0_req_ack), 32'(acc && win == 0));
        chk("s1_ack", 32'(s1_req_ack), 32'(acc && win == 1));
        chk("s0_resp", 32'(s0_resp), 32'(er[0]));
        chk("s1_resp", 32'(s1_resp), 32'(er[1]));
        chk("s0_rdata", s0_rdata, imem_rdata);
        chk("s1_rdata", s1_rdata, imem_rdata);
        last_ack[0] = acc && win == 0;
        last_ack[1] = acc && win == 1;

        if (rst) begin
            mq.delete();
            lock_own = -1;
            rr       = 0;
            m_err    = 0;
        end else begin
            if (imem_resp != 2'b00 && mq.size() == 0) m_err = 1;
            if (popd) void'(mq.pop_front());
            if (!full) begin
                if (lock_own >= 0) begin
                    if (acc || !r[lock_own]) lock_own = -1;
                end else if (e_req && !imem_req_ack) begin
                    lock_own = win;
                end
            end
            if (acc) begin
                mq.push_back(win);
                rr = (win == 0) ? 1 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        s0_req = 0; s1_req = 0; imem_req_ack = 0;
        for (int i = 0; i < 10 && mq.size() > 0; i++) begin
            imem_resp  = 2'b01;
            imem_rdata = $urandom;
            cyc();
        end
        imem_resp = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1; s0_req = 0; s1_req = 0; imem_req_ack = 0; imem_resp = 2'b00;
        cyc();
        rst = 0;
    endtask

    initial begin
        logic [1:0] rseq[4];
        int         ridx;
        rseq[0] = 2'b01; rseq[1] = 2'b01; rseq[2] = 2'b10; rseq[3] = 2'b01;
        rst = 1; s0_req = 0; s1_req = 0; s0_addr = 0; s1_addr = 0;
        imem_req_ack = 0; imem_rdata = 0; imem_resp = 2'b00;
        @(negedge clk);
        cyc(); cyc();
        rst = 0;

        // reset state, idle
        #1; chk("rst_req", 32'(imem_req), 0); chk("rst_err", 32'(err_unexp_resp), 0);
        cyc();

        // single port
        s0_req = 1; s0_addr = 32'h100; imem_req_ack = 1;
        #1; chk("sp_ack", 32'(s0_req_ack), 1); chk("sp_addr", imem_addr, 32'h100);
        cyc();
        s0_req = 0; imem_req_ack = 0;
        cyc(); cyc();
        imem_resp = 2'b01; imem_rdata = 32'hDEADBEEF;
        #1; chk("sp_resp", 32'(s0_resp), 1); chk("sp_rdata", s0_rdata, 32'hDEADBEEF);
        chk("sp_s1resp", 32'(s1_resp), 0);
        cyc();
        imem_resp = 2'b00;

        // round-robin contention
        do_reset();
        s0_req = 1; s0_addr = 32'h200; s1_req = 1; s1_addr = 32'h300; imem_req_ack = 1;
        ridx = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin s0_req = 0; s1_req = 0; end
            if (mq.size() > 0 && ridx < 4) begin
                imem_resp = rseq[ridx]; ridx++;
            end else imem_resp = 2'b00;
            imem_rdata = $urandom;
            #1;
            if (i < 4) chk("rr_gnt", 32'(s1_req_ack), 32'(i % 2));
            cyc();
        end
        imem_resp = 2'b00;
        drain();

        // lock: s1 held while ack low, s0 waits
        s1_req = 1; s1_addr = 32'h400; imem_req_ack = 0;
        #1; chk("lk_addr0", imem_addr, 32'h400);
        cyc();
        s0_req = 1; s0_addr = 32'h500;
        for (int i = 0; i < 3; i++) begin
            #1; chk("lk_addr", imem_addr, 32'h400);
            cyc();
        end
        imem_req_ack = 1;
        #1; chk("lk_s1ack", 32'(s1_req_ack), 1); chk("lk_s0ack", 32'(s0_req_ack), 0);
        cyc();
        s1_req = 0;
        #1; chk("lk_s0gnt", 32'(s0_req_ack), 1); chk("lk_s0addr", imem_addr, 32'h500);
        cyc();
        drain();

        // lock owner drops request
        s0_req = 1; imem_req_ack = 0;
        cyc();
        s0_req = 0; s1_req = 1; s1_addr = 32'h600;
        #1; chk("drop_req", 32'(imem_req), 0);
        cyc();
        #1; chk("drop_addr", imem_addr, 32'h600);
        imem_req_ack = 1;
        cyc();
        drain();

        // full
        s0_req = 1; s0_addr = 32'h700; imem_req_ack = 1;
        cyc(); cyc();
        #1; chk("full_req", 32'(imem_req), 0); chk("full_ack", 32'(s0_req_ack), 0);
        cyc();
        imem_resp = 2'b01;
        #1; chk("full_popN", 32'(imem_req), 0);
        cyc();
        imem_resp = 2'b00;
        #1; chk("full_N1", 32'(imem_req), 1);
        cyc();
        drain();

        // unexpected response
        imem_resp = 2'b01;
        #1; chk("ux_s0", 32'(s0_resp), 0); chk("ux_s1", 32'(s1_resp), 0);
        cyc();
        imem_resp = 2'b00;
        cyc();
        #1; chk("ux_sticky", 32'(err_unexp_resp), 1);
        cyc();

        // reset mid-flight
        do_reset();
        s0_req = 1; s1_req = 1; imem_req_ack = 1;
        cyc(); cyc();
        do_reset();
        imem_resp = 2'b01;
        #1; chk("rmf_s0", 32'(s0_resp), 0); chk("rmf_s1", 32'(s1_resp), 0);
        cyc();
        imem_resp = 2'b00;
        s0_req = 1; s1_req = 1; imem_req_ack = 1;
        #1; chk("rmf_err", 32'(err_unexp_resp), 1); chk("rmf_s0first", 32'(s0_req_ack), 1);
        cyc();
        s0_req = 0;
        cyc();
        drain();

        // randomized traffic
        do_reset();
        last_ack[0] = 0; last_ack[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(s0_req && !last_ack[0])) begin
                s0_req = 1'($urandom_range(1, 0)); s0_addr = $urandom;
            end
            if (!(s1_req && !last_ack[1])) begin
                s1_req = 1'($urandom_range(1, 0)); s1_addr = $urandom;
            end
            imem_req_ack = 1'($urandom_range(1, 0));
            imem_rdata   = $urandom;
            if (mq.size() > 0)
                imem_resp = ($urandom_range(1, 0) == 1) ? 2'($urandom_range(2, 1)) : 2'b00;
            else
                imem_resp = ($urandom_range(99, 0) < 3) ? 2'b01 : 2'b00;
            rst = ($urandom_range(199, 0) == 0);
            cyc();
            rst = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
